press_count_sched: RTL and testbench

//  Front-end controller for the press counter: conditions two raw push-buttons (up/down),

---
 rtl/press_count_sched_pkg.sv | 20 ++
 rtl/press_count_sched_debounce.sv | 78 +++++++
 rtl/press_count_sched.sv | 148 ++++++++++++++
 tb/tb_press_count_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/press_count_sched_pkg.sv
// Shared definitions for the press counter front end: FSM encodings, direction codes, defaults.
// Optional auto-repeat is enabled by defining PRESS_AUTOREPEAT_EN.
package press_count_sched_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE_UP = 2'd1;
    localparam logic [1:0] ST_ISSUE_DN = 2'd2;
    localparam logic [1:0] ST_GAP      = 2'd3;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Bits needed for a counter that runs 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/press_count_sched_debounce.sv
// One button input path: 2-flop synchroniser, stability debounce, press pulse.
// With PRESS_AUTOREPEAT_EN defined, a held button also emits periodic repeat pulses.
module press_count_sched_debounce
    import press_count_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef PRESS_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            press_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            accept;
    logic            rep_fire;

    assign accept = (sync2_q != stable_q) && (db_cnt_q == DB_LAST);

`ifdef PRESS_AUTOREPEAT_EN
    localparam int RP_W = cnt_width(REPEAT_DELAY);
    logic [RP_W-1:0] rep_q;

    // After the first repeat the timer restarts one period short of the delay.
    assign rep_fire = stable_q && (rep_q == RP_W'(REPEAT_DELAY - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_q <= '0;
        end else if (!stable_q) begin
            rep_q <= '0;
        end else if (rep_fire) begin
            rep_q <= RP_W'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
            rep_q <= rep_q + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if ((sync2_q == stable_q) || accept) begin
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
            if (accept) begin
                stable_q <= sync2_q;
            end
            press_q <= (accept && sync2_q) || rep_fire;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/press_count_sched.sv
// Press scheduler: debounced up/down events are queued in saturating counters and issued
// one pulse at a time with a forced gap. Auto-repeat is enabled by defining PRESS_AUTOREPEAT_EN.
module press_count_sched
    import press_count_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int PEND_W          = 4,
    parameter int GAP_CYCLES      = 1
`ifdef PRESS_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
`endif
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              clear_drop,
    output logic              countu,
    output logic              countd,
    output logic [PEND_W-1:0] pending_up,
    output logic [PEND_W-1:0] pending_down,
    output logic              busy,
    output logic              drop
);

    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // Index 0 is the up direction, index 1 the down direction.
    logic [1:0] btn_raw;
    logic [1:0] press_ev;
    logic [1:0] issue;
    logic [1:0] nonzero;
    logic [1:0] overflow;

    logic [1:0]       state_q, state_d;
    logic             last_dir_q, last_dir_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             countu_q, countd_q, busy_q, drop_q;
    logic             arb;

    assign btn_raw = {btn_down, btn_up};
    assign issue   = {state_q == ST_ISSUE_DN, state_q == ST_ISSUE_UP};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [PEND_W-1:0] pend_q;

        press_count_sched_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef PRESS_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_debounce (
            .clk_i  (clock0),
            .rst_ni (reset),
            .btn_i  (btn_raw[gi]),
            .press_o(press_ev[gi])
        );

        assign nonzero[gi]  = |pend_q;
        assign overflow[gi] = press_ev[gi] && !issue[gi] && (&pend_q);

        always_ff @(posedge clock0 or negedge reset) begin
            if (!reset) begin
                pend_q <= '0;
            end else if (press_ev[gi] && !issue[gi] && !(&pend_q)) begin
                pend_q <= pend_q + 1'b1;
            end else if (!press_ev[gi] && issue[gi]) begin
                pend_q <= pend_q - 1'b1;
            end
        end
    end

    // The last GAP clock arbitrates like IDLE so pulses can be GAP_CYCLES+1 apart.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        gap_cnt_d  = gap_cnt_q;
        arb        = 1'b0;
        case (state_q)
            ST_IDLE: arb = 1'b1;
            ST_ISSUE_UP: begin
                state_d    = ST_GAP;
                last_dir_d = DIR_UP;
                gap_cnt_d  = '0;
            end
            ST_ISSUE_DN: begin
                state_d    = ST_GAP;
                last_dir_d = DIR_DN;
                gap_cnt_d  = '0;
            end
            default: begin
                if (gap_cnt_q == GAP_LAST) begin
                    arb = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
        endcase
        if (arb) begin
            if (nonzero[0] && nonzero[1]) begin
                state_d = (last_dir_q == DIR_UP) ? ST_ISSUE_DN : ST_ISSUE_UP;
            end else if (nonzero[0]) begin
                state_d = ST_ISSUE_UP;
            end else if (nonzero[1]) begin
                state_d = ST_ISSUE_DN;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_dir_q <= DIR_DN;
            gap_cnt_q  <= '0;
            countu_q   <= 1'b0;
            countd_q   <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            gap_cnt_q  <= gap_cnt_d;
            countu_q   <= (state_d == ST_ISSUE_UP);
            countd_q   <= (state_d == ST_ISSUE_DN);
            busy_q     <= (state_d != ST_IDLE);
            if (|overflow) begin
                drop_q <= 1'b1;
            end else if (clear_drop) begin
                drop_q <= 1'b0;
            end
        end
    end

    assign countu       = countu_q;
    assign countd       = countd_q;
    assign busy         = busy_q;
    assign drop         = drop_q;
    assign pending_up   = g_btn[0].pend_q;
    assign pending_down = g_btn[1].pend_q;

endmodule

// File: tb/tb_press_count_sched.sv
// Scoreboard bench for press_count_sched: expected pulse directions are queued as buttons are
// driven and popped as pulses appear. Define PRESS_AUTOREPEAT_EN to exercise auto-repeat.
module tb_press_count_sched;

    localparam int DB = 4;
    localparam int PW = 2;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a_up = 1'b0, a_dn = 1'b0, a_clr = 1'b0;
    logic b_up = 1'b0, b_dn = 1'b0, b_clr = 1'b0;
    logic a_cu, a_cd, a_busy, a_drop, b_cu, b_cd, b_busy, b_drop;
    logic [PW-1:0] a_pu, a_pd, b_pu, b_pd;

    always #5 clk = ~clk;

    press_count_sched #(
        .DEBOUNCE_CYCLES(DB), .PEND_W(PW), .GAP_CYCLES(1)
`ifdef PRESS_AUTOREPEAT_EN
        , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
    ) dut_a (
        .clock0(clk), .reset(rst_n), .btn_up(a_up), .btn_down(a_dn), .clear_drop(a_clr),
        .countu(a_cu), .countd(a_cd), .pending_up(a_pu), .pending_down(a_pd),
        .busy(a_busy), .drop(a_drop)
    );

    // Second instance with a long gap so a backlog can build up and saturate.
    press_count_sched #(
        .DEBOUNCE_CYCLES(DB), .PEND_W(PW), .GAP_CYCLES(100)
`ifdef PRESS_AUTOREPEAT_EN
        , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
    ) dut_b (
        .clock0(clk), .reset(rst_n), .btn_up(b_up), .btn_down(b_dn), .clear_drop(b_clr),
        .countu(b_cu), .countd(b_cd), .pending_up(b_pu), .pending_down(b_pd),
        .busy(b_busy), .drop(b_drop)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Repeat events expected while the debounced level stays high for n clocks.
    function automatic int rep_extra(input int n);
        int k;
        rep_extra = 0;
`ifdef PRESS_AUTOREPEAT_EN
        for (k = RD; k <= n; k += RP) rep_extra++;
`else
        k = n;
`endif
    endfunction

    byte exp_a[$];
    byte exp_b[$];
    int  a_last = -100, b_last = -100;
    int  a_u_first = -1, a_u_cyc = -1, a_d_cyc = -1, a_d_n = 0, a_count = 0;
    int  b_u_n = 0, b_pu_max = 0;
    byte got_a, got_b;

    always @(negedge clk) begin
        if (rst_n && (a_cu || a_cd)) begin
            got_a = a_cu ? "U" : "D";
            $display("[%0d] A pulse %s pend_up=%0d pend_dn=%0d", cyc, got_a, a_pu, a_pd);
            check("A_exclusive", {31'd0, a_cu & a_cd}, 0);
            check("A_gap", {31'd0, (cyc - a_last) >= 2}, 1);
            a_last = cyc;
            if (exp_a.size() == 0) check("A_extra_pulse", 1, 0);
            else check("A_dir", got_a, exp_a.pop_front());
            if (a_cu) begin
                a_u_cyc = cyc;
                if (a_u_first < 0) a_u_first = cyc;
                a_count++;
            end else begin
                a_d_cyc = cyc;
                a_d_n++;
                a_count--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(b_pu) > b_pu_max) b_pu_max = int'(b_pu);
            if (b_cu || b_cd) begin
                got_b = b_cu ? "U" : "D";
                $display("[%0d] B pulse %s pend_up=%0d drop=%0d", cyc, got_b, b_pu, b_drop);
                check("B_exclusive", {31'd0, b_cu & b_cd}, 0);
                check("B_gap", {31'd0, (cyc - b_last) >= 101}, 1);
                b_last = cyc;
                if (exp_b.size() == 0) check("B_extra_pulse", 1, 0);
                else check("B_dir", got_b, exp_b.pop_front());
                if (b_cu) b_u_n++;
            end
        end
    end

    int t0;
    int waited;

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        step(3);
        check("rst_countu", {31'd0, a_cu}, 0);
        check("rst_countd", {31'd0, a_cd}, 0);
        check("rst_pend_up", {30'd0, a_pu}, 0);
        check("rst_pend_dn", {30'd0, a_pd}, 0);
        check("rst_busy", {31'd0, a_busy}, 0);
        check("rst_drop", {31'd0, a_drop}, 0);
        rst_n = 1'b1;
        step(2);

        // Clean 20-clock press on up: fixed latency, pending/busy timeline
        for (int i = 0; i < 1 + rep_extra(20); i++) exp_a.push_back("U");
        a_up = 1'b1;
        t0 = cyc;
        step(DB + 3);
        check("lat_pend_up", {30'd0, a_pu}, 1);
        check("lat_busy_pre", {31'd0, a_busy}, 0);
        step(1);
        check("lat_countu", {31'd0, a_cu}, 1);
        check("lat_busy", {31'd0, a_busy}, 1);
        step(1);
        check("lat_countu_off", {31'd0, a_cu}, 0);
        check("lat_pend_up_done", {30'd0, a_pu}, 0);
        step(20 - DB - 5);
        a_up = 1'b0;
        step(30);
        check("latency", a_u_first - t0, DB + 4);
        check("A_q_empty_1", exp_a.size(), 0);

        // Bouncing down button: five 1-clock glitches, then steady
        for (int i = 0; i < 1 + rep_extra(10); i++) exp_a.push_back("D");
        for (int i = 0; i < 5; i++) begin
            a_dn = 1'b1; step(1);
            a_dn = 1'b0; step(1);
        end
        a_dn = 1'b1; step(10);
        a_dn = 1'b0; step(30);
        check("bounce_count", a_d_n, 1 + rep_extra(10));
        check("A_q_empty_2", exp_a.size(), 0);

        // Simultaneous presses: UP first (last grant was DOWN), then DOWN two clocks later
        for (int i = 0; i < 1 + rep_extra(12); i++) begin
            exp_a.push_back("U");
            exp_a.push_back("D");
        end
        a_u_cyc = -1;
        a_d_cyc = -1;
        a_up = 1'b1; a_dn = 1'b1;
        step(DB + 7);
        check("simul_spacing", a_d_cyc - a_u_cyc, 2);
        step(12 - DB - 7);
        a_up = 1'b0; a_dn = 1'b0;
        step(40);
        check("A_q_empty_3", exp_a.size(), 0);
        check("A_net_count", a_count, 0);

        // Backlog on B: a down press opens a long gap, then five up presses saturate
        exp_b.push_back("D");
        b_dn = 1'b1; step(6);
        b_dn = 1'b0; step(14);
        for (int i = 0; i < 5; i++) begin
            b_up = 1'b1; step(6);
            b_up = 1'b0; step(10);
        end
        check("B_pend_peak", b_pu_max, 3);
        check("B_pend_now", {30'd0, b_pu}, 3);
        check("B_drop_set", {31'd0, b_drop}, 1);
        b_clr = 1'b1; step(1);
        b_clr = 1'b0;
        check("B_drop_clear", {31'd0, b_drop}, 0);
        for (int i = 0; i < 3; i++) exp_b.push_back("U");
        waited = 0;
        while (exp_b.size() != 0 && waited < 600) begin
            step(1);
            waited++;
        end
        step(5);
        check("B_q_empty", exp_b.size(), 0);
        check("B_countu_total", b_u_n, 3);
        check("B_pend_final", {30'd0, b_pu}, 0);

        // Reset while a countu pulse is on the wire
        exp_a.push_back("U");
        a_up = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!a_cu && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_seen", {31'd0, a_cu}, 1);
        check("rst_mid_pend_before", {30'd0, a_pu}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_countu", {31'd0, a_cu}, 0);
        check("rst_mid_pend_up", {30'd0, a_pu}, 0);
        check("rst_mid_busy", {31'd0, a_busy}, 0);
        check("rst_mid_drop", {31'd0, a_drop}, 0);
        a_up = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(30);
        check("A_q_empty_4", exp_a.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
